// File: rtl/inst_packer_if.sv
// Field-set / memory-write bus of the instruction packer.
// The slave side is the packer; the master side is the loader plus memory.
interface inst_packer_if #(
    parameter int ADDR_W = 12
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [1:0]        fmt_i;
    logic [2:0]        op_i;
    logic [2:0]        func_i;
    logic [2:0]        rd_i;
    logic [2:0]        rs_i;
    logic [2:0]        rs2_i;
    logic [7:0]        immed_i;
    logic [11:0]       addr_i;
    logic [2:0]        count_i;
    logic              load_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic              mem_we_o;
    logic              mem_ready_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [17:0]       mem_data_o;
    logic              halted_o;
    logic [15:0]       words_o;

    modport slave (
        input  in_valid_i, fmt_i, op_i, func_i, rd_i, rs_i, rs2_i, immed_i,
               addr_i, count_i, load_i, base_addr_i, mem_ready_i,
        output in_ready_o, mem_we_o, mem_addr_o, mem_data_o, halted_o, words_o
    );

    modport master (
        output in_valid_i, fmt_i, op_i, func_i, rd_i, rs_i, rs2_i, immed_i,
               addr_i, count_i, load_i, base_addr_i, mem_ready_i,
        input  in_ready_o, mem_we_o, mem_addr_o, mem_data_o, halted_o, words_o
    );
endinterface

// File: rtl/inst_packer.sv
// Packs decoded instruction fields into 18-bit words, queues them in a small
// FIFO and writes them to instruction RAM at an auto-incrementing address.
module inst_packer #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4,
    parameter int WRAP   = 0
) (
    input  logic         clk,
    input  logic         rst,
    inst_packer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] TOP_ADDR = '1;
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        FMT_R     = 2'd0,
        FMT_I     = 2'd1,
        FMT_J     = 2'd2,
        FMT_SHIFT = 2'd3
    } fmt_t;

    // Only op[1:0] is encoded; R and shift formats force bit 17 high.
    function automatic logic [17:0] encode(
        input logic [1:0]  fmt,
        input logic [1:0]  op,
        input logic [2:0]  func,
        input logic [2:0]  rd,
        input logic [2:0]  rs,
        input logic [2:0]  rs2,
        input logic [7:0]  immed,
        input logic [11:0] jaddr,
        input logic [2:0]  count
    );
        logic [17:0] w;
        w = '0;
        case (fmt_t'(fmt))
            FMT_R:     w = {1'b1, op, 1'b0, rd, rs, rs2, 2'b00, func};
            FMT_I:     w = {1'b0, func, rd, rs, immed};
            FMT_J:     w = {1'b0, func, 2'b00, jaddr};
            FMT_SHIFT: w = {1'b1, op, 1'b0, rd, rs, count, 2'b00, func};
            default:   w = '0;
        endcase
        return w;
    endfunction

    logic [17:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    cnt;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] addr_q;
    logic              halted_q;
    logic [15:0]       words_q;
    logic [17:0]       enc_word;
    logic              unused_op_msb;

    assign unused_op_msb = bus.op_i[2];

    assign enc_word = encode(bus.fmt_i, bus.op_i[1:0], bus.func_i, bus.rd_i,
                             bus.rs_i, bus.rs2_i, bus.immed_i, bus.addr_i,
                             bus.count_i);

    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    // No bypass: a pop in the same cycle does not free a slot for the push.
    assign push  = bus.in_valid_i && !full;
    assign pop   = bus.mem_we_o && bus.mem_ready_i;

    assign bus.in_ready_o = !full;
    assign bus.mem_we_o   = !empty && !halted_q;
    assign bus.mem_data_o = empty ? 18'd0 : fifo_mem[rd_ptr];
    assign bus.mem_addr_o = addr_q;
    assign bus.halted_o   = halted_q;
    assign bus.words_o    = words_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= enc_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + (PTR_W+1)'(1);
                2'b01:   cnt <= cnt - (PTR_W+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Load takes priority over a concurrent write: that write lands at the
    // old address but is neither counted nor allowed to advance the address.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            halted_q <= 1'b0;
            words_q  <= '0;
        end else if (bus.load_i) begin
            addr_q   <= bus.base_addr_i;
            halted_q <= 1'b0;
            words_q  <= '0;
        end else if (pop) begin
            if (addr_q == TOP_ADDR) begin
                if (WRAP != 0) begin
                    addr_q <= '0;
                end else begin
                    halted_q <= 1'b1;
                end
            end else begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            if (words_q != 16'hFFFF) begin
                words_q <= words_q + 16'd1;
            end
        end
    end
endmodule

// File: doc/inst_packer.md
Name: inst_packer

Overview:
- Encoder and loader for 18-bit instructions, the inverse of the instruction field splitter.
- Accepts decoded instruction fields plus a format code over a valid/ready handshake and packs them into 18-bit words.
- Buffers packed words in a 4-entry FIFO and drains them into the instruction memory write port at an auto-incrementing address.
- Used by the program loader and the self-test sequencer to build programs in instruction RAM.

Parameters:
ADDR_W, 12, instruction memory address width
DEPTH, 4, FIFO entries (power of 2, >=2)
WRAP, 0, 1: address wraps 2^ADDR_W-1 -> 0; 0: halt at top address

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid_i  in  1  field set valid
in_ready_o  out  1  packer can accept a field set
fmt_i  in  2  0=R, 1=I, 2=J, 3=shift
op_i  in  3  opcode; only [1:0] used (R/shift force bit17=1)
func_i  in  3  function code
rd_i, rs_i, rs2_i  in  3 each  register fields
immed_i  in  8  immediate
addr_i  in  12  jump address
count_i  in  3  shift count
load_i  in  1  load address counter
base_addr_i  in  ADDR_W  value loaded on load_i
mem_we_o  out  1  memory write request
mem_ready_i  in  1  memory accepts write this cycle
mem_addr_o  out  ADDR_W  write address
mem_data_o  out  18  packed instruction
halted_o  out  1  sticky: top address written with WRAP=0
words_o  out  16  count of words written since rst/load

Behaviour:
- Reset (rst=1 at posedge): FIFO empty, address=0, words_o=0, halted_o=0. Outputs then read in_ready_o=1, mem_we_o=0, mem_data_o=0, mem_addr_o=0. Reset mid-drain discards all FIFO contents.
- Encoding, pure function of fields (unused bits are 0):
  - R: {1, op[1:0], 0, rd, rs, rs2, 00, func}
  - I: {0, func, rd, rs, immed}
  - J: {0, func, 00, addr}
  - shift: {1, op[1:0], 0, rd, rs, count, 00, func}
- Push: in_valid_i && in_ready_o at posedge writes the encoded word into the FIFO. in_ready_o = !full. There is no bypass, so in_ready_o stays 0 when full even if a pop occurs that cycle.
- Latency: a word accepted at edge N is visible on mem_data_o with mem_we_o=1 from cycle N+1 if the FIFO was empty.
- mem_we_o = !empty && !halted_o. mem_data_o is the FIFO head (registered); it is 0 when empty.
- Pop/write: mem_we_o && mem_ready_i at posedge. The write uses the current mem_addr_o; the address then increments and words_o increments (saturating at 0xFFFF).
- Push and pop in the same cycle: occupancy unchanged, order preserved.
- Top address (2^ADDR_W-1) written:
  - WRAP=1: next address is 0.
  - WRAP=0: halted_o set, address holds, mem_we_o=0 afterwards. Remaining FIFO entries are retained; in_ready_o still follows full.
- load_i:
  - Next address = base_addr_i; halted_o and words_o cleared.
  - A write in the same cycle uses the old address and is not counted (load wins).
  - FIFO contents are untouched.
- mem_addr_o is always the current address register.

Test Plan:
- R push op=101, func=011, rd=2, rs=3, rs2=5, mem_ready_i=1 -> next cycle mem_we_o=1, mem_data_o=0x293A3 at addr 0x000; addr becomes 0x001, words_o=1.
- I func=110, rd=1, rs=4, immed=0x5A -> 0x18C5A. J func=010, addr=0xABC -> 0x08ABC. Shift uses count in [7:5] with bit17=1.
- mem_ready_i=0, push 5 words back-to-back -> in_ready_o drops after 4th accept, 5th held. Then raise mem_ready_i -> 4 writes in order at consecutive addresses; in_ready_o returns 1 after first pop.
- load_i with base_addr_i=0xFFE, WRAP=0, 3 words -> writes at 0xFFE, 0xFFF, then halted_o=1, mem_we_o=0, 3rd word retained. Next load_i base=0x010 -> 3rd word written at 0x010.
- WRAP=1, base=0xFFF, 2 words -> writes at 0xFFF then 0x000, halted_o stays 0.
- rst asserted with 3 words queued -> next cycle mem_we_o=0, in_ready_o=1, addr=0, words_o=0. load_i concurrent with a write -> old address written, next addr=base, words_o=0.
